// File: rtl/payment_ledger.sv
// Vending-machine transaction ledger: latches price, accumulates coins, resolves confirm/cancel.
// Optional idle auto-refund in COLLECT is enabled by defining LEDGER_TIMEOUT_EN.
module payment_ledger #(
  parameter int unsigned MAX_CREDIT     = 99,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       in_money_one,
  input  logic       in_money_five,
  input  logic       in_money_ten,
  input  logic       in_money_twenty,
  input  logic       in_money_fifty,
  input  logic       price_load,
  input  logic [7:0] price_value,
  input  logic       sys_Confirm,
  input  logic       sys_Cancel,
  input  logic       sys_Change,
  output logic [7:0] need_money,
  output logic [7:0] input_money,
  output logic [7:0] change_money,
  output logic [1:0] state_code,
  output logic       dispense,
  output logic       refund,
  output logic       coin_reject,
  output logic       nak
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam logic [8:0] MaxCredit = 9'(MAX_CREDIT);

  state_e     state_q, state_d;
  logic [7:0] need_q, need_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] change_q, change_d;
  logic       dispense_q, dispense_d;
  logic       refund_q, refund_d;
  logic       reject_q, reject_d;
  logic       nak_q, nak_d;

  logic [4:0] coins;
  logic       coin_any;
  logic       coin_multi;
  logic [7:0] coin_val;
  logic [8:0] sum;
  logic       coin_ok;
  logic       timeout;
  logic       cancel_eff;

  // Only the highest denomination present in a cycle is considered.
  always_comb begin
    coins      = {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one};
    coin_any   = |coins;
    coin_multi = (coins & (coins - 5'd1)) != 5'd0;
    if (in_money_fifty)       coin_val = 8'd50;
    else if (in_money_twenty) coin_val = 8'd20;
    else if (in_money_ten)    coin_val = 8'd10;
    else if (in_money_five)   coin_val = 8'd5;
    else if (in_money_one)    coin_val = 8'd1;
    else                      coin_val = 8'd0;
    sum = {1'b0, credit_q} + {1'b0, coin_val};
  end

`ifdef LEDGER_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  assign timeout = (state_q == StCollect) && (idle_q >= TIMEOUT_CYCLES - 32'd1) &&
                   !coin_any && !sys_Confirm && !sys_Cancel;

  always_comb begin
    idle_d = 32'd0;
    if (state_q == StCollect && state_d == StCollect && !coin_ok && !nak_d) begin
      idle_d = idle_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) idle_q <= 32'd0;
    else            idle_q <= idle_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  assign cancel_eff = sys_Cancel | timeout;

  always_comb begin
    state_d    = state_q;
    need_d     = need_q;
    credit_d   = credit_q;
    change_d   = change_q;
    dispense_d = 1'b0;
    refund_d   = 1'b0;
    reject_d   = 1'b0;
    nak_d      = 1'b0;
    coin_ok    = 1'b0;
    unique case (state_q)
      StIdle: begin
        reject_d = coin_any;
        if (price_load && price_value != 8'd0) begin
          need_d   = price_value;
          credit_d = 8'd0;
          change_d = 8'd0;
          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (cancel_eff) begin
          change_d = credit_q;
          credit_d = 8'd0;
          refund_d = 1'b1;
          reject_d = coin_any;
          state_d  = StDone;
        end else if (sys_Confirm) begin
          reject_d = coin_any;
          if (credit_q >= need_q) begin
            change_d   = credit_q - need_q;
            dispense_d = 1'b1;
            state_d    = StDone;
          end else begin
            nak_d = 1'b1;
          end
        end else if (coin_any) begin
          reject_d = coin_multi;
          if (sum <= MaxCredit) begin
            credit_d = sum[7:0];
            coin_ok  = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StDone: begin
        reject_d = coin_any;
        if (sys_Change) begin
          need_d   = 8'd0;
          credit_d = 8'd0;
          change_d = 8'd0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      need_q     <= 8'd0;
      credit_q   <= 8'd0;
      change_q   <= 8'd0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      reject_q   <= 1'b0;
      nak_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      need_q     <= need_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      dispense_q <= dispense_d;
      refund_q   <= refund_d;
      reject_q   <= reject_d;
      nak_q      <= nak_d;
    end
  end

  assign need_money   = need_q;
  assign input_money  = credit_q;
  assign change_money = change_q;
  assign state_code   = state_q;
  assign dispense     = dispense_q;
  assign refund       = refund_q;
  assign coin_reject  = reject_q;
  assign nak          = nak_q;

endmodule

// File: tb/tb_payment_ledger.sv
// Bench for payment_ledger: directed scenarios plus randomized pulses against a
// cycle-level reference model of the ledger rules.
module tb_payment_ledger;

  localparam int Max = 99;
  localparam int To  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c1, c5, c10, c20, c50;
  logic       pl;
  logic [7:0] pv;
  logic       cf, cn, chg;
  logic [7:0] need_money, input_money, change_money;
  logic [1:0] state_code;
  logic       dispense, refund, coin_reject, nak;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_state, m_need, m_in, m_chg, m_idle;
  int e_disp, e_ref, e_rej, e_nak;

  always #5 clk = ~clk;

  payment_ledger #(
    .MAX_CREDIT    (Max),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .in_money_one   (c1),
    .in_money_five  (c5),
    .in_money_ten   (c10),
    .in_money_twenty(c20),
    .in_money_fifty (c50),
    .price_load     (pl),
    .price_value    (pv),
    .sys_Confirm    (cf),
    .sys_Cancel     (cn),
    .sys_Change     (chg),
    .need_money     (need_money),
    .input_money    (input_money),
    .change_money   (change_money),
    .state_code     (state_code),
    .dispense       (dispense),
    .refund         (refund),
    .coin_reject    (coin_reject),
    .nak            (nak)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    rst_n = 1'b1;
    {c1, c5, c10, c20, c50} = 5'b0;
    pl = 1'b0; pv = 8'd0; cf = 1'b0; cn = 1'b0; chg = 1'b0;
  endtask

  // Apply the spec rules to the inputs held during the cycle just clocked.
  task automatic model_step();
    int vals[5];
    int hits[5];
    int n, best, nxt;
    bit evt, tmo, accepted;
    vals = '{1, 5, 10, 20, 50};
    hits = '{int'(c1), int'(c5), int'(c10), int'(c20), int'(c50)};
    n = 0; best = 0;
    for (int i = 0; i < 5; i++) begin
      if (hits[i] != 0) begin
        n++;
        best = vals[i];
      end
    end
    e_disp = 0; e_ref = 0; e_rej = 0; e_nak = 0;
    accepted = 0;
    if (!rst_n) begin
      m_state = 0; m_need = 0; m_in = 0; m_chg = 0; m_idle = 0;
      return;
    end
    evt = (n > 0) || cf || cn;
    tmo = 0;
`ifdef LEDGER_TIMEOUT_EN
    tmo = (m_state == 1) && !evt && (m_idle >= To - 1);
`endif
    nxt = m_state;
    if (m_state == 0) begin
      if (n > 0) e_rej = 1;
      if (pl && pv != 0) begin
        m_need = pv; m_in = 0; m_chg = 0; nxt = 1;
      end
    end else if (m_state == 1) begin
      if (cn || tmo) begin
        m_chg = m_in; m_in = 0; e_ref = 1; nxt = 2;
        if (n > 0) e_rej = 1;
      end else if (cf) begin
        if (n > 0) e_rej = 1;
        if (m_in >= m_need) begin
          m_chg = m_in - m_need; e_disp = 1; nxt = 2;
        end else begin
          e_nak = 1;
        end
      end else if (n > 0) begin
        if (n > 1) e_rej = 1;
        if (m_in + best <= Max) begin
          m_in += best; accepted = 1;
        end else begin
          e_rej = 1;
        end
      end
    end else begin
      if (n > 0) e_rej = 1;
      if (chg) begin
        m_need = 0; m_in = 0; m_chg = 0; nxt = 0;
      end
    end
    if (nxt == 1 && m_state == 1 && !accepted && !e_nak) m_idle++;
    else m_idle = 0;
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_eq("state", state_code, m_state);
    check_eq("need", need_money, m_need);
    check_eq("credit", input_money, m_in);
    check_eq("change", change_money, m_chg);
    check_eq("dispense", dispense, e_disp);
    check_eq("refund", refund, e_ref);
    check_eq("reject", coin_reject, e_rej);
    check_eq("nak", nak, e_nak);
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    tick();
    check_eq("rst_state", state_code, 0);
    check_eq("rst_need", need_money, 0);
    clear_in();

    // Price 12, coins 10 + 5, confirm -> change 3
    pl = 1; pv = 8'd12; tick(); clear_in();
    c10 = 1; tick(); clear_in();
    c5 = 1; tick(); clear_in();
    cf = 1; tick(); clear_in();
    check_eq("t1_disp", dispense, 1);
    check_eq("t1_chg", change_money, 3);
    check_eq("t1_state", state_code, 2);
    chg = 1; tick(); clear_in();
    check_eq("t1_idle", state_code, 0);
    check_eq("t1_zero", {need_money, input_money, change_money}, 0);

    // Price 30: nak at 20, dispense at 30
    pl = 1; pv = 8'd30; tick(); clear_in();
    c20 = 1; tick(); clear_in();
    cf = 1; tick(); clear_in();
    check_eq("t2_nak", nak, 1);
    check_eq("t2_credit", input_money, 20);
    c10 = 1; tick(); clear_in();
    cf = 1; tick(); clear_in();
    check_eq("t2_disp", dispense, 1);
    check_eq("t2_chg", change_money, 0);
    chg = 1; tick(); clear_in();

    // Price 5, 50 + 50 overflows, cancel refunds 50
    pl = 1; pv = 8'd5; tick(); clear_in();
    c50 = 1; tick(); clear_in();
    c50 = 1; tick(); clear_in();
    check_eq("t3_rej", coin_reject, 1);
    check_eq("t3_credit", input_money, 50);
    cn = 1; tick(); clear_in();
    check_eq("t3_ref", refund, 1);
    check_eq("t3_chg", change_money, 50);
    check_eq("t3_credit0", input_money, 0);
    chg = 1; tick(); clear_in();

    // Price 25, credit 10, one + twenty + confirm together
    pl = 1; pv = 8'd25; tick(); clear_in();
    c10 = 1; tick(); clear_in();
    c1 = 1; c20 = 1; cf = 1; tick(); clear_in();
    check_eq("t4_nak", nak, 1);
    check_eq("t4_rej", coin_reject, 1);
    check_eq("t4_credit", input_money, 10);

    // Reset mid-transaction at credit 15
    c5 = 1; tick(); clear_in();
    check_eq("t5_credit", input_money, 15);
    rst_n = 0; tick(); clear_in();
    check_eq("t5_ref", refund, 0);
    check_eq("t5_state", state_code, 0);
    check_eq("t5_credit0", input_money, 0);
    c1 = 1; tick(); clear_in();
    check_eq("t5_rej", coin_reject, 1);

`ifdef LEDGER_TIMEOUT_EN
    pl = 1; pv = 8'd9; tick(); clear_in();
    c5 = 1; tick(); clear_in();
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq("to_ref", refund, (k == 16) ? 1 : 0);
    end
    check_eq("to_chg", change_money, 5);
    chg = 1; tick(); clear_in();
`endif

    // Randomized pulses
    for (int i = 0; i < 600; i++) begin
      clear_in();
      rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      c1  = ($urandom_range(99) < 10);
      c5  = ($urandom_range(99) < 10);
      c10 = ($urandom_range(99) < 10);
      c20 = ($urandom_range(99) < 10);
      c50 = ($urandom_range(99) < 8);
      pl  = ($urandom_range(99) < 15);
      pv  = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(60));
      cf  = ($urandom_range(99) < 10);
      cn  = ($urandom_range(99) < 4);
      chg = ($urandom_range(99) < 15);
      tick();
    end
    clear_in();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
